// File: rtl/if_stage_pc_reg.sv
// Instruction-fetch PC register, IF/ID pipeline register and imem req/ready handshake with a one-entry skid buffer.
// Optional sticky misalignment trap is enabled by defining IF_ALIGN_TRAP_EN.
module if_stage_pc_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
`ifdef IF_ALIGN_TRAP_EN
  output logic        if_id_valid,
  output logic        misalign
`else
  output logic        if_id_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] skid_r;
  logic [31:0] if_id_instr_r;
  logic [31:0] if_id_pc_r;
  logic        if_id_valid_r;
  logic        imem_req_r;
  logic        accept_s;
  logic        pc_load_s;
  logic [31:0] pc_load_val_s;
  logic        mis_next_s;

  // A response only counts while a request is actually outstanding.
  assign accept_s = imem_req_r & imem_ready;

`ifdef IF_ALIGN_TRAP_EN
  logic misalign_r;

  // The PC takes the raw target; a misaligned load sets the sticky trap flag.
  always_comb begin
    pc_load_val_s = pc_next;
    if (pc_load_s) begin
      mis_next_s = misalign_r | (pc_next[1:0] != 2'b00);
    end else begin
      mis_next_s = misalign_r;
    end
  end

  // Sticky alignment error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= mis_next_s;
    end
  end

  assign misalign = misalign_r;
`else
  // Without the trap, low address bits are dropped so the PC stays word aligned.
  always_comb begin
    pc_load_val_s = pc_next & 32'hFFFF_FFFC;
    mis_next_s    = 1'b0;
  end
`endif

  // Cycles in which the PC advances to pc_next.
  always_comb begin
    pc_load_s = 1'b0;
    if (flush) begin
      pc_load_s = 1'b1;
    end else begin
      case (state_r)
        FETCH:   pc_load_s = accept_s & ~stall;
        HOLD:    pc_load_s = ~stall;
        default: pc_load_s = 1'b0;
      endcase
    end
  end

  // Fetch FSM: PC, skid buffer, IF/ID register and the registered request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      skid_r        <= NOP_INSTR;
      if_id_instr_r <= NOP_INSTR;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
      imem_req_r    <= 1'b0;
    end else if (flush) begin
      state_r       <= FETCH;
      pc_r          <= pc_load_val_s;
      skid_r        <= NOP_INSTR;
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
      imem_req_r    <= ~mis_next_s;
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= FETCH;
          imem_req_r <= ~mis_next_s;
        end
        FETCH: begin
          if (accept_s && !stall) begin
            if_id_instr_r <= imem_instr;
            if_id_pc_r    <= pc_r;
            if_id_valid_r <= ~mis_next_s;
            pc_r          <= pc_load_val_s;
            imem_req_r    <= ~mis_next_s;
          end else if (accept_s) begin
            // Response arrived under stall: park it until the stall clears.
            skid_r     <= imem_instr;
            state_r    <= HOLD;
            imem_req_r <= 1'b0;
          end else if (!stall) begin
            if_id_valid_r <= 1'b0;
          end else begin
            if_id_valid_r <= if_id_valid_r;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_instr_r <= skid_r;
            if_id_pc_r    <= pc_r;
            if_id_valid_r <= ~mis_next_s;
            pc_r          <= pc_load_val_s;
            state_r       <= FETCH;
            imem_req_r    <= ~mis_next_s;
          end else begin
            imem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          if_id_valid_r <= 1'b0;
          imem_req_r    <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_r;
  assign pc_plus4    = pc_r + PC_STEP;
  assign imem_req    = imem_req_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_pc    = if_id_pc_r;
  assign if_id_valid = if_id_valid_r;

endmodule
